sat_accumulator: RTL and testbench
==================================

Name: sat_accumulator

Overview:
- Multi-lane streaming saturating accumulator for the matrix-multiply datapath.
- Sums a variable-length group of signed operands per lane (one dot-product row segment); group end is marked by in_last.
- Presents the per-lane sums with sticky overflow flags over a valid/ready output handshake.
- Generalises the single-shot two-operand saturating adder to parametrised width, lane count, group length and wrap/saturate mode.

Parameters:
- WIDTH, 32, signed operand/result width per lane.
- LANES, 4, independent accumulator lanes sharing one handshake.
- CNT_W, 8, width of the beat counter.
- SAT_EN, 1, 1 = saturate on overflow, 0 = two's-complement wrap (overflow still flagged).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*WIDTH  lane i operand at [i*WIDTH +: WIDTH], signed.
- in_last  in  1  beat is final of the group.
- out_valid  out  1  group result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  LANES*WIDTH  per-lane final sums, same packing as in_data.
- out_ovf  out  LANES  per-lane sticky overflow flag for the group.
- out_count  out  CNT_W  beats in the group; saturates at 2^CNT_W-1.

Behaviour:
- Reset:
  - state=ACCUM; all accumulators, out_data, out_ovf and out_count = 0; out_valid = 0.
  - in_ready = 1 from the first clock after rst deasserts.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- ACCUM transfer (in_valid && in_ready), per lane:
  - acc <= f(acc, op); ovf_i |= overflow; count <= min(count+1, 2^CNT_W-1).
  - If in_last: the result of that same addition is loaded into out_data/out_ovf/out_count; state -> HOLD next cycle.
- Latency:
  - out_valid rises on the clock edge that accepts the in_last beat, so it is visible the following cycle.
  - One bubble per group (in_ready = 0 during HOLD).
- Arithmetic per step:
  - The sum is formed at WIDTH+1 bits.
  - Overflow = both operands share a sign and the WIDTH-bit sum sign differs.
  - SAT_EN=1: positive overflow clamps to 2^(WIDTH-1)-1, negative to -2^(WIDTH-1).
  - SAT_EN=0: the wrapped sum is kept.
  - Clamping is applied every step, so the result is order-dependent. This is intended; do not defer saturation to group end.
- HOLD:
  - out_data, out_ovf and out_count stay stable while out_ready = 0.
  - On out_valid && out_ready: accumulators, ovf and count clear to 0; state -> ACCUM next cycle.
  - in_valid is ignored in HOLD; no beat is consumed.
- Boundaries:
  - Single-beat group (in_last on first beat): out_data = operand, count = 1.
  - in_valid low mid-group: accumulators hold indefinitely.
  - Counter at max: stays at max, accumulation continues.
  - rst mid-group or during HOLD: partial sums and pending result are discarded, and all outputs return to reset values immediately.
  - out_ready high while not in HOLD: no effect.

Decomposition:
- Shared package sat_pkg holds:
  - state encoding constants (ACCUM, HOLD);
  - lane-slice helper macros/localparams for max/min derivation from WIDTH.
- Sub-module sat_add_lane:
  - combinational WIDTH-parametrised saturating adder with SAT_EN;
  - outputs sum and ovf;
  - instantiated LANES times via generate.
- The top level owns the FSM, counter and output registers.

Test Plan:
- Stimulus for all scenarios: WIDTH=32, LANES=2, SAT_EN=1 unless stated.
1. Basic group: lane0 beats 5, 7, -3 (last) -> out_valid the cycle after last accept; out_data lane0 = 9; out_count = 3; out_ovf = 00.
2. Positive clamp: lane1 0x7FFFFFF0, 0x20, -1 (last) -> step 2 clamps to 0x7FFFFFFF; result 0x7FFFFFFE; out_ovf[1] = 1; lane0 unaffected.
3. Negative clamp: lane0 0x80000005, -10 (last) -> 0x80000000; out_ovf[0] = 1.
4. Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_data stable, in_ready = 0, no beat consumed. Raise out_ready -> next group starts from 0.
5. Wrap mode (SAT_EN=0): 0x7FFFFFFF, 1 (last) -> 0x80000000 with out_ovf = 1.
6. Reset mid-group: 2 beats of 100, then pulse rst -> all outputs 0 immediately. A following single beat 4 (last) yields 4, count 1.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared definitions for the saturating accumulator.
//   state_t : ACCUM (taking beats) / HOLD (result presented, input stalled)
package sat_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add_lane.sv
// Combinational signed adder for one lane, with optional saturation.
//   a, b : signed operands (WIDTH bits)
//   sum  : clamped sum (SAT_EN=1) or wrapped sum (SAT_EN=0)
//   ovf  : signed overflow of a+b, flagged in both modes
module sat_add_lane #(
    parameter int WIDTH  = 32,
    parameter int SAT_EN = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] wide;

    always_comb begin
        wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        // Same-sign operands whose WIDTH-bit result flips sign have overflowed.
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        sum  = wide[WIDTH-1:0];
        if (ovf && (SAT_EN != 0))
            sum = a[WIDTH-1] ? MAX_NEG : MAX_POS;
    end

endmodule

// File: rtl/sat_accumulator.sv
// Multi-lane streaming saturating accumulator.
// Each accepted beat adds in_data lane i into accumulator i; the beat marked
// in_last loads the final sums, sticky overflow flags and beat count into the
// output registers and the block holds them until out_ready.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input beat handshake (ready only while accumulating)
//   in_data, in_last   : LANES packed signed operands, end-of-group marker
//   out_valid/out_ready: result handshake
//   out_data           : per-lane final sums, same packing as in_data
//   out_ovf            : per-lane sticky overflow for the group
//   out_count          : beats in the group, saturating at 2^CNT_W-1
module sat_accumulator
    import sat_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8,
    parameter int SAT_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    output logic [CNT_W-1:0]       out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    logic [LANES-1:0][WIDTH-1:0] acc, sum, res;
    logic [LANES-1:0]            ovf, lane_ovf, res_ovf;
    logic [CNT_W-1:0]            count, count_inc, res_count;
    logic                        accept, done;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_add_lane #(
            .WIDTH  (WIDTH),
            .SAT_EN (SAT_EN)
        ) u_add (
            .a   (acc[i]),
            .b   (in_data[i*WIDTH +: WIDTH]),
            .sum (sum[i]),
            .ovf (lane_ovf[i])
        );
    end

    assign accept    = in_valid && in_ready;
    assign done      = out_valid && out_ready;
    assign count_inc = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;

    assign out_data  = res;
    assign out_ovf   = res_ovf;
    assign out_count = res_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                // Held low while rst is asserted so nothing is taken in reset.
                in_ready = !rst;
                if (accept && in_last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Saturation is applied at every beat, so results depend on beat order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= '0;
            count     <= '0;
            res       <= '0;
            res_ovf   <= '0;
            res_count <= '0;
        end else if (accept) begin
            acc   <= sum;
            ovf   <= ovf | lane_ovf;
            count <= count_inc;
            if (in_last) begin
                res       <= sum;
                res_ovf   <= ovf | lane_ovf;
                res_count <= count_inc;
            end
        end else if (done) begin
            // Result registers keep the last group; only running state clears.
            acc   <= '0;
            ovf   <= '0;
            count <= '0;
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
module tb_sat_accumulator;

    localparam int W = 32;
    localparam int L = 2;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0, in_valid_w = 1'b0;
    logic [L*W-1:0] in_data = '0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;

    logic           in_ready, out_valid, in_ready_w, out_valid_w;
    logic [L*W-1:0] out_data, out_data_w;
    logic [L-1:0]   out_ovf, out_ovf_w;
    logic [C-1:0]   out_count, out_count_w;

    int n_chk  = 0;
    int n_fail = 0;
    bit use_wrap = 1'b0;

    always #5 clk = ~clk;

    sat_accumulator #(.WIDTH(W), .LANES(L), .CNT_W(C), .SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .out_count(out_count)
    );

    sat_accumulator #(.WIDTH(W), .LANES(L), .CNT_W(C), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w),
        .out_count(out_count_w)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One beat, presented at a negedge, accepted at the next posedge.
    task automatic beat(input logic [31:0] d0, input logic [31:0] d1, input logic last);
        @(negedge clk);
        chk("in_ready", use_wrap ? in_ready_w : in_ready, 1'b1);
        in_data = {d1, d0};
        in_last = last;
        if (use_wrap) in_valid_w = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_w = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [1:0] eovf, input logic [7:0] ecnt);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".lane0"}, out_data[31:0], e0);
        chk({tag, ".lane1"}, out_data[63:32], e1);
        chk({tag, ".ovf"},   out_ovf, eovf);
        chk({tag, ".count"}, out_count, ecnt);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.data", out_data, 64'h0);
        chk("rst.count", out_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1'b1);

        // Basic group: 5 + 7 - 3 = 9
        beat(32'd5, 32'd0, 1'b0);
        beat(32'd7, 32'd0, 1'b0);
        chk("basic.not_yet_valid", out_valid, 1'b0);
        beat(32'hFFFF_FFFD, 32'd0, 1'b1);
        chk_out("basic", 32'd9, 32'd0, 2'b00, 8'd3);
        chk("basic.in_ready_hold", in_ready, 1'b0);
        drain();
        chk("basic.drained", out_valid, 1'b0);

        // Positive clamp on lane1, lane0 = 1+2+3
        beat(32'd1, 32'h7FFF_FFF0, 1'b0);
        beat(32'd2, 32'h0000_0020, 1'b0);
        beat(32'd3, 32'hFFFF_FFFF, 1'b1);
        chk_out("posclamp", 32'd6, 32'h7FFF_FFFE, 2'b10, 8'd3);

        // Backpressure: in_valid high while holding, nothing consumed
        in_data  = {32'd111, 32'd111};
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.in_ready", in_ready, 1'b0);
            chk("bp.data", out_data, {32'h7FFF_FFFE, 32'd6});
            chk("bp.count", out_count, 8'd3);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();
        beat(32'd10, 32'd20, 1'b1);
        chk_out("after_bp", 32'd10, 32'd20, 2'b00, 8'd1);
        drain();

        // Negative clamp on lane0
        beat(32'h8000_0005, 32'd0, 1'b0);
        beat(32'hFFFF_FFF6, 32'd0, 1'b1);
        chk_out("negclamp", 32'h8000_0000, 32'd0, 2'b01, 8'd2);
        drain();

        // Counter saturation: 260 beats of 1 -> sum 260, count stuck at 255
        for (int i = 0; i < 260; i++) beat(32'd1, 32'd2, (i == 259));
        chk_out("cntsat", 32'd260, 32'd520, 2'b00, 8'd255);
        drain();

        // Wrap mode instance: 0x7FFFFFFF + 1 wraps and flags
        use_wrap = 1'b1;
        beat(32'h7FFF_FFFF, 32'd0, 1'b0);
        beat(32'd1, 32'd0, 1'b1);
        use_wrap = 1'b0;
        chk("wrap.valid", out_valid_w, 1'b1);
        chk("wrap.lane0", out_data_w[31:0], 32'h8000_0000);
        chk("wrap.ovf", out_ovf_w, 2'b01);
        chk("wrap.count", out_count_w, 8'd2);
        chk("wrap.main_idle", out_valid, 1'b0);
        drain();

        // Reset mid-group: outputs clear at once, next group starts clean
        beat(32'd100, 32'd100, 1'b0);
        beat(32'd100, 32'd100, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.data", out_data, 64'h0);
        chk("midrst.ovf", out_ovf, 2'b00);
        chk("midrst.count", out_count, 8'd0);
        chk("midrst.valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        beat(32'd4, 32'd0, 1'b1);
        chk_out("after_rst", 32'd4, 32'd0, 2'b00, 8'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
